// File: rtl/fighter_pkg.sv
// Shared types and key map for the two-player keycode event decoder.
// Action codes, HID keycodes, the event record and the scan length live here.
package fighter_pkg;

  typedef enum logic [2:0] {
    ACT_UP    = 3'd0,
    ACT_LEFT  = 3'd1,
    ACT_DOWN  = 3'd2,
    ACT_RIGHT = 3'd3,
    ACT_PUNCH = 3'd4
  } action_e;

  localparam logic [7:0] KC_RYU_UP      = 8'h1A;
  localparam logic [7:0] KC_RYU_LEFT    = 8'h04;
  localparam logic [7:0] KC_RYU_DOWN    = 8'h16;
  localparam logic [7:0] KC_RYU_RIGHT   = 8'h07;
  localparam logic [7:0] KC_RYU_PUNCH   = 8'h09;
  localparam logic [7:0] KC_AKUMA_UP    = 8'h52;
  localparam logic [7:0] KC_AKUMA_LEFT  = 8'h50;
  localparam logic [7:0] KC_AKUMA_DOWN  = 8'h51;
  localparam logic [7:0] KC_AKUMA_RIGHT = 8'h4F;
  localparam logic [7:0] KC_AKUMA_PUNCH = 8'h0F;

  localparam int NUM_ACTIONS = 5;
  localparam int SCAN_LEN    = 10;

  typedef struct packed {
    logic    player;
    logic    press;
    action_e action;
  } key_event_t;

  // One-hot contribution of a single slot: bit i = player*5 + action.
  function automatic logic [SCAN_LEN-1:0] decode_keycode(input logic [7:0] kc);
    logic [SCAN_LEN-1:0] hit;
    hit = '0;
    case (kc)
      KC_RYU_UP:      hit[0] = 1'b1;
      KC_RYU_LEFT:    hit[1] = 1'b1;
      KC_RYU_DOWN:    hit[2] = 1'b1;
      KC_RYU_RIGHT:   hit[3] = 1'b1;
      KC_RYU_PUNCH:   hit[4] = 1'b1;
      KC_AKUMA_UP:    hit[5] = 1'b1;
      KC_AKUMA_LEFT:  hit[6] = 1'b1;
      KC_AKUMA_DOWN:  hit[7] = 1'b1;
      KC_AKUMA_RIGHT: hit[8] = 1'b1;
      KC_AKUMA_PUNCH: hit[9] = 1'b1;
      default:        hit = '0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/keycode_event_fifo.sv
// Show-ahead event FIFO: head entry is presented whenever not empty.
// A push while full succeeds only if a pop happens in the same cycle.
module keycode_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
  end

  assign head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/keycode_event_decoder.sv
// Turns four HID keycode slots into per-player held vectors and press/release events.
// Optional punch auto-repeat is enabled by defining KEY_REPEAT_EN.
module keycode_event_decoder
  import fighter_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int REPEAT_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode_0,
  input  logic [7:0] keycode_1,
  input  logic [7:0] keycode_2,
  input  logic [7:0] keycode_3,
  input  logic       frame_tick,
  output logic [4:0] p1_held,
  output logic [4:0] p2_held,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [4:0] evt_data,
  output logic       overflow
);

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_FRAMES < 1) begin : g_param_check
    $error("keycode_event_decoder: FIFO_DEPTH must be a power of two >= 4, REPEAT_FRAMES >= 1");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [SCAN_LEN-1:0] held_q, held_d;
  logic [SCAN_LEN-1:0] mask_q, mask_d;
  logic                overflow_q, overflow_d;
  logic [SCAN_LEN-1:0] held_now;
  logic [SCAN_LEN-1:0] rpt_mask;
  logic                frame_accept;
  logic                push;
  key_event_t          push_evt;
  logic [2:0]          act_idx;
  logic                fifo_full, fifo_empty;
  logic [4:0]          head_data;

  assign held_now = decode_keycode(keycode_0) | decode_keycode(keycode_1) |
                    decode_keycode(keycode_2) | decode_keycode(keycode_3);

  assign frame_accept = (state_q == ST_IDLE) && frame_tick;

`ifdef KEY_REPEAT_EN
  localparam int CW = $clog2(REPEAT_FRAMES + 1);

  logic [1:0][CW-1:0] rpt_cnt_q, rpt_cnt_d;

  // Counters only move on accepted frames; a repeat marks the punch bit for the coming scan.
  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    rpt_mask  = '0;
    if (frame_accept) begin
      for (int p = 0; p < 2; p++) begin
        if (held_now[p*NUM_ACTIONS + int'(ACT_PUNCH)] && held_q[p*NUM_ACTIONS + int'(ACT_PUNCH)]) begin
          if (rpt_cnt_q[p] == CW'(REPEAT_FRAMES - 1)) begin
            rpt_cnt_d[p] = '0;
            rpt_mask[p*NUM_ACTIONS + int'(ACT_PUNCH)] = 1'b1;
          end else begin
            rpt_cnt_d[p] = rpt_cnt_q[p] + CW'(1);
          end
        end else begin
          rpt_cnt_d[p] = '0;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`else
  assign rpt_mask = '0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    held_d   = held_q;
    mask_d   = mask_q;
    push     = 1'b0;
    push_evt = '0;
    act_idx  = '0;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          held_d  = held_now;
          mask_d  = (held_now ^ held_q) | rpt_mask;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        act_idx = (idx_q >= 4'd5) ? 3'(idx_q - 4'd5) : idx_q[2:0];
        if (mask_q[idx_q]) begin
          push            = 1'b1;
          push_evt.player = (idx_q >= 4'd5);
          push_evt.press  = held_q[idx_q];
          push_evt.action = action_e'(act_idx);
        end
        if (idx_q == 4'(SCAN_LEN - 1)) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A full queue without a same-cycle pop drops the event; the flag stays set until reset.
  always_comb begin
    overflow_d = overflow_q | (push && fifo_full && !evt_ready);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      held_q     <= '0;
      mask_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      held_q     <= held_d;
      mask_q     <= mask_d;
      overflow_q <= overflow_d;
    end
  end

  keycode_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(key_event_t))
  ) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (push),
    .push_data (push_evt),
    .pop       (evt_ready),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign p1_held   = held_q[4:0];
  assign p2_held   = held_q[9:5];
  assign evt_valid = !fifo_empty;
  assign evt_data  = head_data;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keycode_event_decoder.sv
// Scoreboard bench for keycode_event_decoder; honours KEY_REPEAT_EN when defined.
// Expected events come from a frame-level model of the key map and edge/repeat rules.
module tb_keycode_event_decoder;

  localparam int DEPTH = 8;
  localparam int RPT   = 8;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] keycode_0 = '0;
  logic [7:0] keycode_1 = '0;
  logic [7:0] keycode_2 = '0;
  logic [7:0] keycode_3 = '0;
  logic       frame_tick = 1'b0;
  logic       evt_ready = 1'b0;
  logic [4:0] p1_held, p2_held, evt_data;
  logic       evt_valid, overflow;

  keycode_event_decoder #(
    .FIFO_DEPTH    (DEPTH),
    .REPEAT_FRAMES (RPT)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .keycode_0  (keycode_0),
    .keycode_1  (keycode_1),
    .keycode_2  (keycode_2),
    .keycode_3  (keycode_3),
    .frame_tick (frame_tick),
    .p1_held    (p1_held),
    .p2_held    (p2_held),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_data   (evt_data),
    .overflow   (overflow)
  );

  always #5 Clk = ~Clk;

  int         total_checks = 0;
  int         bad_checks   = 0;
  int         events_seen  = 0;
  logic [4:0] exp_q [$];
  logic [4:0] mon_exp;
  logic [9:0] m_held = '0;
  int         m_cnt [2] = '{0, 0};
  logic       m_overflow = 1'b0;
  logic [7:0] key_table [10] = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h09,
                                 8'h52, 8'h50, 8'h51, 8'h4F, 8'h0F};

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  function automatic logic [9:0] model_decode(input logic [7:0] kc);
    logic [9:0] v;
    v = '0;
    for (int i = 0; i < 10; i++) if (kc == key_table[i]) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_held     = '0;
    m_cnt[0]   = 0;
    m_cnt[1]   = 0;
    m_overflow = 1'b0;
  endtask

  // nopop=1 means the consumer is stalled, so queue length equals FIFO occupancy.
  task automatic model_frame(input bit nopop);
    logic [9:0] nw, ch, rep;
    logic [4:0] ev;
    nw  = model_decode(keycode_0) | model_decode(keycode_1) |
          model_decode(keycode_2) | model_decode(keycode_3);
    ch  = nw ^ m_held;
    rep = '0;
`ifdef KEY_REPEAT_EN
    for (int p = 0; p < 2; p++) begin
      if (nw[p*5+4] && m_held[p*5+4]) begin
        m_cnt[p]++;
        if (m_cnt[p] == RPT) begin
          rep[p*5+4] = 1'b1;
          m_cnt[p]   = 0;
        end
      end else begin
        m_cnt[p] = 0;
      end
    end
`endif
    for (int i = 0; i < 10; i++) begin
      if (ch[i] || rep[i]) begin
        ev = {(i >= 5) ? 1'b1 : 1'b0, nw[i], 3'(i % 5)};
        if (nopop && exp_q.size() >= DEPTH) m_overflow = 1'b1;
        else exp_q.push_back(ev);
      end
    end
    m_held = nw;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Issues one accepted frame and checks the held vectors right after the snapshot edge.
  task automatic apply_stimulus(input logic [7:0] k0, input logic [7:0] k1,
                                input logic [7:0] k2, input logic [7:0] k3, input bit nopop);
    keycode_0  = k0;
    keycode_1  = k1;
    keycode_2  = k2;
    keycode_3  = k3;
    frame_tick = 1'b1;
    @(posedge Clk);
    #1;
    frame_tick = 1'b0;
    model_frame(nopop);
    check_output("p1_held", 32'(p1_held), 32'(m_held[4:0]));
    check_output("p2_held", 32'(p2_held), 32'(m_held[9:5]));
  endtask

  task automatic drain();
    int guard;
    guard     = 0;
    evt_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge Clk);
      #1;
      guard++;
    end
    check_output("drain_left", 32'(exp_q.size()), 32'd0);
    check_output("no_extra_event", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    model_reset();
    #1;
    check_output("rst_valid", 32'(evt_valid), 32'd0);
    check_output("rst_overflow", 32'(overflow), 32'd0);
    check_output("rst_p1", 32'(p1_held), 32'd0);
    check_output("rst_p2", 32'(p2_held), 32'd0);
    check_output("rst_data", 32'(evt_data), 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    wait_cycles(1);
  endtask

  function automatic logic [7:0] rand_key();
    int r;
    r = $urandom_range(0, 13);
    if (r < 10) return key_table[r];
    if (r < 12) return 8'h00;
    return 8'($urandom);
  endfunction

  always @(negedge Clk) begin
    if (!Reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        total_checks++;
        bad_checks++;
        $display("[TB] FAIL unexpected_event: got %0h required none", evt_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check_output("evt_data", 32'(evt_data), 32'(mon_exp));
        events_seen++;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Asynchronous reset before any clock edge.
    #1;
    Reset = 1'b1;
    model_reset();
    #2;
    check_output("async_rst_valid", 32'(evt_valid), 32'd0);
    check_output("async_rst_overflow", 32'(overflow), 32'd0);
    check_output("async_rst_p1", 32'(p1_held), 32'd0);
    check_output("async_rst_data", 32'(evt_data), 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    wait_cycles(2);

    // Latency of the first event.
    apply_stimulus(8'h1A, 8'h00, 8'h00, 8'h00, 1'b0);
    check_output("valid_before_push", 32'(evt_valid), 32'd0);
    @(posedge Clk);
    #1;
    check_output("valid_latency", 32'(evt_valid), 32'd1);
    check_output("first_data", 32'(evt_data), 32'h08);
    wait_cycles(10);
    drain();

    // Ordering of presses and releases.
    apply_stimulus(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    wait_cycles(11);
    drain();
    apply_stimulus(8'h09, 8'h4F, 8'h04, 8'h00, 1'b0);
    wait_cycles(11);
    drain();
    apply_stimulus(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    wait_cycles(11);
    drain();

    // Tick during SCAN with different keys is ignored.
    apply_stimulus(8'h1A, 8'h52, 8'h00, 8'h00, 1'b0);
    wait_cycles(2);
    keycode_0  = 8'h16;
    keycode_1  = 8'h0F;
    frame_tick = 1'b1;
    @(posedge Clk);
    #1;
    frame_tick = 1'b0;
    keycode_0  = 8'h1A;
    keycode_1  = 8'h52;
    wait_cycles(10);
    drain();
    apply_stimulus(8'h1A, 8'h52, 8'h00, 8'h00, 1'b0);
    wait_cycles(11);
    drain();

    // Reset at SCAN index 3 discards pending events.
    apply_stimulus(8'h1A, 8'h04, 8'h16, 8'h07, 1'b0);
    wait_cycles(3);
    check_output("pre_reset_valid", 32'(evt_valid), 32'd1);
    do_reset();
    wait_cycles(12);
    check_output("post_reset_valid", 32'(evt_valid), 32'd0);
    check_output("post_reset_overflow", 32'(overflow), 32'd0);
    apply_stimulus(8'h1A, 8'h04, 8'h16, 8'h07, 1'b0);
    wait_cycles(11);
    drain();

    // Overflow with a stalled consumer.
    keycode_0 = 8'h00; keycode_1 = 8'h00; keycode_2 = 8'h00; keycode_3 = 8'h00;
    do_reset();
    apply_stimulus(8'h1A, 8'h04, 8'h16, 8'h07, 1'b1);
    wait_cycles(11);
    apply_stimulus(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    wait_cycles(11);
    apply_stimulus(8'h09, 8'h00, 8'h00, 8'h00, 1'b1);
    wait_cycles(11);
    check_output("overflow_set", 32'(overflow), 32'(m_overflow));
    check_output("queued_valid", 32'(evt_valid), 32'd1);
    drain();
    check_output("overflow_sticky", 32'(overflow), 32'd1);

    // Full queue with a pop in the same cycle as a push.
    keycode_0 = 8'h00; keycode_1 = 8'h00; keycode_2 = 8'h00; keycode_3 = 8'h00;
    do_reset();
    apply_stimulus(8'h1A, 8'h04, 8'h16, 8'h07, 1'b1);
    wait_cycles(11);
    apply_stimulus(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    wait_cycles(11);
    apply_stimulus(8'h09, 8'h00, 8'h00, 8'h00, 1'b0);
    wait_cycles(4);
    evt_ready = 1'b1;
    @(posedge Clk);
    #1;
    evt_ready = 1'b0;
    wait_cycles(7);
    check_output("full_pop_no_overflow", 32'(overflow), 32'd0);
    drain();

    // Punch held for 17 frames.
    keycode_0 = 8'h00; keycode_1 = 8'h00; keycode_2 = 8'h00; keycode_3 = 8'h00;
    do_reset();
    events_seen = 0;
    repeat (17) begin
      apply_stimulus(8'h09, 8'h00, 8'h00, 8'h00, 1'b0);
      wait_cycles(11);
      drain();
    end
`ifdef KEY_REPEAT_EN
    check_output("punch_event_count", 32'(events_seen), 32'd3);
`else
    check_output("punch_event_count", 32'(events_seen), 32'd1);
`endif

    // Random frames with a randomly stalling consumer.
    for (int f = 0; f < 40; f++) begin
      apply_stimulus(rand_key(), rand_key(), rand_key(), rand_key(), 1'b0);
      for (int c = 0; c < 11; c++) begin
        evt_ready = ($urandom_range(0, 3) != 0);
        @(posedge Clk);
        #1;
      end
      evt_ready = 1'b0;
      drain();
    end
    check_output("random_overflow", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
